// File: rtl/pet2001_pkg.sv
// Shared constants and state encoding for the PET video capture path.
package pet2001_pkg;

  localparam int H_ACTIVE = 320;
  localparam int V_ACTIVE = 200;
  localparam int BPL      = H_ACTIVE / 8;
  localparam int ADDR_W   = 13;

  typedef enum logic [1:0] {
    WAIT_VBL = 2'd0,
    WAIT_FRM = 2'd1,
    ACTIVE   = 2'd2
  } vcap_state_t;

endpackage

// File: rtl/pet2001_vcap_wrbuf.sv
// One-entry framebuffer write register: holds addr/data stable while req is up,
// flags a completed byte that arrives while the previous one is still unacked.
module pet2001_vcap_wrbuf #(
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              ack,
  output logic              req,
  output logic [ADDR_W-1:0] addr,
  output logic [7:0]        data,
  output logic              ovf
);

  // An ack in the same cycle frees the slot, so the new byte can take it.
  assign ovf = wr && req && !ack;

  always_ff @(posedge clk) begin
    if (reset) begin
      req  <= 1'b0;
      addr <= '0;
      data <= '0;
    end else if (wr && (!req || ack)) begin
      req  <= 1'b1;
      addr <= wr_addr;
      data <= wr_data;
    end else if (req && ack) begin
      req <= 1'b0;
    end
  end

endmodule

// File: rtl/pet2001_vcapture.sv
// Packs the serial PET pixel stream (pix/HBlank/VBlank on ce_pix) back into a
// 1bpp byte framebuffer, MSB = first pixel, and tracks frame geometry.
module pet2001_vcapture #(
  parameter int H_ACTIVE = pet2001_pkg::H_ACTIVE,
  parameter int V_ACTIVE = pet2001_pkg::V_ACTIVE,
  parameter int BPL      = pet2001_pkg::BPL,
  parameter int ADDR_W   = pet2001_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce_pix,
  input  logic              pix,
  input  logic              HBlank,
  input  logic              VBlank,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [7:0]        fb_data,
  output logic              fb_req,
  input  logic              fb_ack,
  output logic              frame_done,
  output logic              locked,
  output logic [2:0]        err
);
  import pet2001_pkg::*;

  localparam int XW = $clog2(H_ACTIVE + 1);
  localparam int LW = $clog2(V_ACTIVE + 2);

  vcap_state_t       state, state_n;
  logic              hb_r, vb_r;
  logic [XW-1:0]     x, x_n;
  logic [LW-1:0]     line, line_n;
  logic [ADDR_W-1:0] line_base, line_base_n;
  logic [7:0]        shreg, shreg_n;
  logic [1:0]        good_cnt, good_cnt_n;
  logic              h_bad, h_bad_n, v_bad, v_bad_n;
  logic [1:0]        gerr, gerr_n;
  logic              done_n, ovf_err, ovf;
  logic              start, run, act, hb_rise, vb_rise, vb_fall;
  logic              wr;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;

  assign hb_rise = HBlank && !hb_r;
  assign vb_rise = VBlank && !vb_r;
  assign vb_fall = !VBlank && vb_r;
  assign act     = !HBlank && !VBlank;

  always_comb begin
    state_n     = state;
    x_n         = x;
    line_n      = line;
    line_base_n = line_base;
    shreg_n     = shreg;
    h_bad_n     = h_bad;
    v_bad_n     = v_bad;
    good_cnt_n  = good_cnt;
    done_n      = 1'b0;
    wr          = 1'b0;
    // The VBlank falling edge may coincide with the first active pixel, so
    // frame start clears the counters and then falls through to pixel handling.
    start = ce_pix && (state == WAIT_FRM) && vb_fall;
    run   = ce_pix && ((state == ACTIVE) || start);
    if (ce_pix && (state == WAIT_VBL) && VBlank) state_n = WAIT_FRM;
    if (start) begin
      x_n         = '0;
      line_n      = '0;
      line_base_n = '0;
      h_bad_n     = 1'b0;
      v_bad_n     = 1'b0;
      state_n     = ACTIVE;
    end
    wr_addr = line_base_n + ADDR_W'(x_n >> 3);
    wr_data = {shreg[6:0], pix};
    if (run) begin
      if (act) begin
        if (x_n >= XW'(H_ACTIVE)) begin
          h_bad_n = 1'b1;
        end else begin
          if (line_n >= LW'(V_ACTIVE)) v_bad_n = 1'b1;
          else if (x_n[2:0] == 3'd7)   wr = 1'b1;
          shreg_n = wr_data;
          x_n     = x_n + 1'b1;
        end
      end
      // Line end is resolved before frame end when both edges share a ce_pix.
      if (hb_rise) begin
        if (x_n != XW'(H_ACTIVE)) h_bad_n = 1'b1;
        if (x_n != '0) begin
          if (line_n < LW'(V_ACTIVE))  line_base_n = line_base_n + ADDR_W'(BPL);
          if (line_n <= LW'(V_ACTIVE)) line_n = line_n + 1'b1;
        end
        x_n = '0;
      end
      if (vb_rise) begin
        if (line_n != LW'(V_ACTIVE)) v_bad_n = 1'b1;
        done_n     = !h_bad_n && !v_bad_n;
        good_cnt_n = done_n ? ((good_cnt == 2'd2) ? 2'd2 : good_cnt + 2'd1) : 2'd0;
        state_n    = WAIT_FRM;
      end
    end
    if (h_bad_n || v_bad_n) good_cnt_n = 2'd0;
    gerr_n = gerr | {v_bad_n, h_bad_n};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= WAIT_VBL;
      hb_r       <= 1'b0;
      vb_r       <= 1'b0;
      x          <= '0;
      line       <= '0;
      line_base  <= '0;
      shreg      <= '0;
      good_cnt   <= '0;
      h_bad      <= 1'b0;
      v_bad      <= 1'b0;
      gerr       <= '0;
      ovf_err    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      x          <= x_n;
      line       <= line_n;
      line_base  <= line_base_n;
      shreg      <= shreg_n;
      good_cnt   <= good_cnt_n;
      h_bad      <= h_bad_n;
      v_bad      <= v_bad_n;
      gerr       <= gerr_n;
      ovf_err    <= ovf_err || ovf;
      frame_done <= done_n;
      if (ce_pix) begin
        hb_r <= HBlank;
        vb_r <= VBlank;
      end
    end
  end

  assign locked = good_cnt[1];
  assign err    = {ovf_err, gerr};

  pet2001_vcap_wrbuf #(.ADDR_W(ADDR_W)) u_wrbuf (
    .clk     (clk),
    .reset   (reset),
    .wr      (wr),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .ack     (fb_ack),
    .req     (fb_req),
    .addr    (fb_addr),
    .data    (fb_data),
    .ovf     (ovf)
  );

endmodule

// File: tb/tb_pet2001_vcapture.sv
// Scoreboard bench: a pixel-stream generator pushes expected framebuffer writes,
// a negedge monitor drives fb_ack and pops/compares on each accepted write.
module tb_pet2001_vcapture;
  localparam int H = 48, V = 8, B = 6, AW = 13, HBL = 8;

  logic          clk = 1'b0, reset = 1'b1, ce_pix = 1'b0, pix = 1'b0;
  logic          HBlank = 1'b0, VBlank = 1'b0, fb_ack = 1'b0;
  logic [AW-1:0] fb_addr;
  logic [7:0]    fb_data;
  logic          fb_req, frame_done, locked;
  logic [2:0]    err;

  always #5 clk = ~clk;

  pet2001_vcapture #(.H_ACTIVE(H), .V_ACTIVE(V), .BPL(B), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .ce_pix(ce_pix), .pix(pix), .HBlank(HBlank),
    .VBlank(VBlank), .fb_addr(fb_addr), .fb_data(fb_data), .fb_req(fb_req),
    .fb_ack(fb_ack), .frame_done(frame_done), .locked(locked), .err(err)
  );

  typedef struct { logic [AW-1:0] addr; logic [7:0] data; } wr_t;
  wr_t exp_q[$];
  int  n_checks = 0, n_errors = 0;
  int  ack_mode = 0, ack_dly = 0, req_age = 0;
  bit  sb_en = 1'b1;
  int  fd_cnt = 0, wr_cnt = 0;
  bit  bad_addr = 1'b0;

  // ack_mode: 0 tied high, 1 ack after req held ack_dly clks, 2 withheld
  always @(negedge clk) begin
    logic a;
    wr_t  e;
    if (frame_done) fd_cnt++;
    case (ack_mode)
      0:       a = 1'b1;
      1:       a = (req_age >= ack_dly);
      default: a = 1'b0;
    endcase
    fb_ack = a;
    if (fb_req && a) begin
      wr_cnt++;
      req_age = 0;
      if (fb_addr >= AW'(V * B)) bad_addr = 1'b1;
      if (sb_en) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_write got addr=%0d data=%h exp none", fb_addr, fb_data);
        end else begin
          e = exp_q.pop_front();
          if (fb_addr !== e.addr || fb_data !== e.data) begin
            n_errors++;
            $display("FAIL write got addr=%0d data=%h exp addr=%0d data=%h",
                     fb_addr, fb_data, e.addr, e.data);
          end
        end
      end
    end else if (fb_req) req_age++;
    else req_age = 0;
  end

  function automatic logic [7:0] pat(input int mode, input int ln, input int k);
    case (mode)
      0:       return 8'hAA;
      1:       return 8'(ln ^ k);
      default: return 8'(8'h5A + k);
    endcase
  endfunction

  task automatic pix_step(input logic p, input logic hb, input logic vb);
    @(negedge clk); ce_pix = 1'b1; pix = p; HBlank = hb; VBlank = vb;
    @(negedge clk); ce_pix = 1'b0;
  endtask

  task automatic gen_line(input int ln, input int len, input int mode, input bit push,
                          input bit vb_in_hbl);
    logic [7:0] d;
    wr_t        e;
    for (int px = 0; px < len; px++) begin
      d = pat(mode, ln, px / 8);
      if (push && (px % 8 == 7) && px < H && ln < V) begin
        e.addr = AW'(ln * B + px / 8);
        e.data = d;
        exp_q.push_back(e);
      end
      pix_step(d[7 - (px % 8)], 1'b0, 1'b0);
    end
    for (int i = 0; i < HBL; i++) pix_step(1'b0, 1'b1, vb_in_hbl);
  endtask

  task automatic gen_vbl(input int n);
    for (int l = 0; l < n; l++) begin
      for (int i = 0; i < H; i++) pix_step(1'($urandom_range(0, 1)), 1'b0, 1'b1);
      for (int i = 0; i < HBL; i++) pix_step(1'b0, 1'b1, 1'b1);
    end
  endtask

  task automatic gen_frame(input int nlines, input int short_ln, input int mode, input bit simul);
    for (int ln = 0; ln < nlines; ln++)
      gen_line(ln, (ln == short_ln) ? H - 4 : H, mode, 1'b1, simul && (ln == nlines - 1));
    gen_vbl(2);
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    exp_q.delete();
    fd_cnt = 0; wr_cnt = 0; bad_addr = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; ack_mode = 0;
    repeat (3) @(negedge clk);
    n_checks++; if ({fb_req, frame_done} !== 2'b00) begin n_errors++; $display("FAIL reset_req_done got=%b exp=00", {fb_req, frame_done}); end
    n_checks++; if ({locked, err} !== 4'b0) begin n_errors++; $display("FAIL reset_locked_err got=%b exp=0000", {locked, err}); end
    n_checks++; if ({fb_addr, fb_data} !== '0) begin n_errors++; $display("FAIL reset_addr_data got=%h/%h exp=0/0", fb_addr, fb_data); end
    reset = 1'b0;
  endtask

  task automatic test_aa_pattern();
    do_reset(); ack_mode = 0;
    gen_vbl(1);
    gen_frame(V, -1, 0, 1'b0);
    n_checks++; if (fd_cnt !== 1) begin n_errors++; $display("FAIL aa_done1 got=%0d exp=1", fd_cnt); end
    n_checks++; if (wr_cnt !== V * B) begin n_errors++; $display("FAIL aa_writes got=%0d exp=%0d", wr_cnt, V * B); end
    n_checks++; if (locked !== 1'b0) begin n_errors++; $display("FAIL aa_locked1 got=%b exp=0", locked); end
    gen_frame(V, -1, 0, 1'b0);
    n_checks++; if (fd_cnt !== 2) begin n_errors++; $display("FAIL aa_done2 got=%0d exp=2", fd_cnt); end
    n_checks++; if (locked !== 1'b1) begin n_errors++; $display("FAIL aa_locked2 got=%b exp=1", locked); end
    n_checks++; if (err !== 3'b000) begin n_errors++; $display("FAIL aa_err got=%b exp=000", err); end
  endtask

  task automatic test_checker_delayed_ack();
    ack_mode = 1; ack_dly = 3;
    gen_frame(V, -1, 1, 1'b1);  // last line: HBlank and VBlank rise together
    n_checks++; if (exp_q.size() !== 0) begin n_errors++; $display("FAIL chk_pending got=%0d exp=0", exp_q.size()); end
    n_checks++; if (err !== 3'b000) begin n_errors++; $display("FAIL chk_err got=%b exp=000", err); end
    n_checks++; if (fd_cnt !== 3) begin n_errors++; $display("FAIL chk_done got=%0d exp=3", fd_cnt); end
    n_checks++; if (locked !== 1'b1) begin n_errors++; $display("FAIL chk_locked got=%b exp=1", locked); end
  endtask

  task automatic test_short_line();
    int w0;
    ack_mode = 0; w0 = wr_cnt;
    for (int ln = 0; ln < V; ln++) begin
      gen_line(ln, (ln == 2) ? H - 4 : H, 1, 1'b1, 1'b0);
      if (ln == 2) begin
        n_checks++; if ({locked, err} !== 4'b0001) begin n_errors++; $display("FAIL short_immediate got=%b exp=0001", {locked, err}); end
      end
    end
    gen_vbl(2);
    n_checks++; if (wr_cnt - w0 !== V * B - 1) begin n_errors++; $display("FAIL short_writes got=%0d exp=%0d", wr_cnt - w0, V * B - 1); end
    n_checks++; if (fd_cnt !== 3) begin n_errors++; $display("FAIL short_done got=%0d exp=3", fd_cnt); end
    n_checks++; if ({locked, err} !== 4'b0001) begin n_errors++; $display("FAIL short_end got=%b exp=0001", {locked, err}); end
    n_checks++; if (exp_q.size() !== 0) begin n_errors++; $display("FAIL short_pending got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_tall_frame();
    do_reset(); ack_mode = 0;
    gen_vbl(1);
    gen_frame(V, -1, 2, 1'b0);
    gen_frame(V, -1, 1, 1'b0);
    n_checks++; if (locked !== 1'b1) begin n_errors++; $display("FAIL tall_pre_locked got=%b exp=1", locked); end
    gen_frame(V + 1, -1, 0, 1'b0);
    n_checks++; if (err !== 3'b010) begin n_errors++; $display("FAIL tall_err got=%b exp=010", err); end
    n_checks++; if (bad_addr !== 1'b0) begin n_errors++; $display("FAIL tall_addr got=%b exp=0", bad_addr); end
    n_checks++; if (locked !== 1'b0) begin n_errors++; $display("FAIL tall_locked got=%b exp=0", locked); end
    n_checks++; if (fd_cnt !== 2) begin n_errors++; $display("FAIL tall_done got=%0d exp=2", fd_cnt); end
    n_checks++; if (wr_cnt !== 3 * V * B) begin n_errors++; $display("FAIL tall_writes got=%0d exp=%0d", wr_cnt, 3 * V * B); end
  endtask

  task automatic test_overflow();
    logic [7:0] d;
    bit         hold_bad;
    do_reset(); ack_mode = 2; sb_en = 1'b0; hold_bad = 1'b0;
    gen_vbl(1);
    for (int px = 0; px < H; px++) begin
      d = pat(2, 0, px / 8);
      pix_step(d[7 - (px % 8)], 1'b0, 1'b0);
      if (px == 7) begin
        n_checks++; if ({fb_req, fb_addr, fb_data} !== {1'b1, AW'(0), 8'h5A}) begin
          n_errors++; $display("FAIL ovf_first got=%b/%0d/%h exp=1/0/5a", fb_req, fb_addr, fb_data);
        end
      end else if (px > 7 && {fb_req, fb_addr, fb_data} !== {1'b1, AW'(0), 8'h5A}) hold_bad = 1'b1;
    end
    n_checks++; if (hold_bad !== 1'b0) begin n_errors++; $display("FAIL ovf_hold got=%b exp=0", hold_bad); end
    n_checks++; if (err !== 3'b100) begin n_errors++; $display("FAIL ovf_err got=%b exp=100", err); end
    ack_mode = 0;
    repeat (3) @(negedge clk);
    n_checks++; if (fb_req !== 1'b0) begin n_errors++; $display("FAIL ovf_release got=%b exp=0", fb_req); end
    n_checks++; if (err !== 3'b100) begin n_errors++; $display("FAIL ovf_sticky got=%b exp=100", err); end
    sb_en = 1'b1;
  endtask

  task automatic test_reset_midframe();
    do_reset(); ack_mode = 0;
    gen_vbl(1);
    gen_frame(V, -1, 0, 1'b0);
    gen_frame(V, -1, 1, 1'b0);
    n_checks++; if (locked !== 1'b1) begin n_errors++; $display("FAIL mid_pre_locked got=%b exp=1", locked); end
    for (int ln = 0; ln < V / 2; ln++) gen_line(ln, H, 2, 1'b1, 1'b0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    n_checks++; if ({fb_req, frame_done, locked, err} !== 6'b0) begin n_errors++; $display("FAIL mid_reset got=%b exp=000000", {fb_req, frame_done, locked, err}); end
    n_checks++; if (exp_q.size() !== 0) begin n_errors++; $display("FAIL mid_pending got=%0d exp=0", exp_q.size()); end
    for (int ln = V / 2; ln < V; ln++) gen_line(ln, H, 2, 1'b0, 1'b0);
    gen_vbl(2);
    fd_cnt = 0;
    gen_frame(V, -1, 1, 1'b0);
    n_checks++; if (fd_cnt !== 1) begin n_errors++; $display("FAIL mid_done got=%0d exp=1", fd_cnt); end
    n_checks++; if (exp_q.size() !== 0) begin n_errors++; $display("FAIL mid_after got=%0d exp=0", exp_q.size()); end
    n_checks++; if ({locked, err} !== 4'b0) begin n_errors++; $display("FAIL mid_state got=%b exp=0000", {locked, err}); end
  endtask

  initial begin
    test_reset();
    test_aa_pattern();
    test_checker_delayed_ack();
    test_short_line();
    test_tall_frame();
    test_overflow();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
